udp_tx_arbiter: RTL and testbench

Packet-level arbiter that shares the single UDP stack transmit interface between two application senders: requester 0 (image stream) and requester 1 (command/status replies). It sits between the senders and the UDP stack and holds a grant for exactly one packet. Grants alternate round-robin. Packets are delimited by counting valid bytes against the latched length. A watchdog releases a stalled grant, and an inter-packet gap is enforced after every packet.

---
 rtl/udp_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UDP transmit port
// between two senders, with watchdog abort and inter-packet gap.
module udp_tx_arbiter #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        udp_tx_ready,
  input  logic        app_tx_ack,
  output logic        app_tx_data_request,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        m0_tx_ready,
  output logic        m0_tx_ack,
  input  logic        m0_data_request,
  input  logic        m0_data_valid,
  input  logic [7:0]  m0_data,
  input  logic [15:0] m0_data_length,
  output logic        m1_tx_ready,
  output logic        m1_tx_ack,
  input  logic        m1_data_request,
  input  logic        m1_data_valid,
  input  logic [7:0]  m1_data,
  input  logic [15:0] m1_data_length,
  output logic [1:0]  grant,
  output logic        pkt_done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    GAP
  } state_t;

  state_t      state;
  logic        last;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [15:0] wd;
  logic [7:0]  gap_cnt;

  logic        sel_req;
  logic        sel_valid;
  logic [7:0]  sel_data;
  logic        pick;

  always_comb begin
    sel_req   = m0_data_request;
    sel_valid = m0_data_valid;
    sel_data  = m0_data;
    if (grant[1]) begin
      sel_req   = m1_data_request;
      sel_valid = m1_data_valid;
      sel_data  = m1_data;
    end
  end

  // On contention the requester not served last wins.
  assign pick = (m0_data_request && m1_data_request)
              ? ~last : m1_data_request;

  assign udp_data_length     = len;
  assign app_tx_data_request = (state == REQ) && sel_req;
  assign app_tx_data_valid   = (state == DATA) && sel_valid;
  assign app_tx_data         = (state == DATA) ? sel_data : 8'h00;

  assign m0_tx_ready = udp_tx_ready &&
    ((state == IDLE) || ((state == REQ) && grant[0]));
  assign m1_tx_ready = udp_tx_ready &&
    ((state == IDLE) || ((state == REQ) && grant[1]));
  assign m0_tx_ack = app_tx_ack && (state == REQ) && grant[0];
  assign m1_tx_ack = app_tx_ack && (state == REQ) && grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last        <= 1'b1;
      len         <= 16'd0;
      cnt         <= 16'd0;
      wd          <= 16'd0;
      gap_cnt     <= 8'd0;
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (udp_tx_ready &&
              (m0_data_request || m1_data_request)) begin
            grant <= pick ? 2'b10 : 2'b01;
            len   <= pick ? m1_data_length : m0_data_length;
            cnt   <= 16'd0;
            state <= REQ;
          end
        end
        REQ: begin
          if (app_tx_ack) begin
            wd <= 16'd0;
            if (len == 16'd0) begin
              pkt_done <= 1'b1;
              last     <= grant[1];
              gap_cnt  <= 8'd0;
              state    <= GAP;
            end else begin
              state <= DATA;
            end
          end else if (!sel_req) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        DATA: begin
          if (sel_valid) begin
            cnt <= cnt + 16'd1;
            wd  <= 16'd0;
            if (cnt == len - 16'd1) begin
              pkt_done <= 1'b1;
              last     <= grant[1];
              gap_cnt  <= 8'd0;
              state    <= GAP;
            end
          end else if (wd == 16'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            last        <= grant[1];
            gap_cnt     <= 8'd0;
            state       <= GAP;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            grant <= 2'b00;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: packet-level reference model with
// per-cycle compare, directed scenarios and randomized traffic.
module tb_udp_tx_arbiter;
  localparam int G  = 16;
  localparam int TO = 100;
  localparam int P_IDLE = 0, P_REQ = 1, P_DATA = 2, P_GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        udp_tx_ready = 1'b0;
  logic        app_tx_ack = 1'b0;
  logic        app_tx_data_request;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic [15:0] udp_data_length;
  logic        m0_tx_ready, m0_tx_ack;
  logic        m1_tx_ready, m1_tx_ack;
  logic        m0_data_request = 1'b0, m0_data_valid = 1'b0;
  logic        m1_data_request = 1'b0, m1_data_valid = 1'b0;
  logic [7:0]  m0_data = 8'h00, m1_data = 8'h80;
  logic [15:0] m0_data_length = 16'd0, m1_data_length = 16'd0;
  logic [1:0]  grant;
  logic        pkt_done, timeout_err;

  udp_tx_arbiter #(.GAP_CYCLES(G), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .udp_tx_ready(udp_tx_ready), .app_tx_ack(app_tx_ack),
    .app_tx_data_request(app_tx_data_request),
    .app_tx_data_valid(app_tx_data_valid),
    .app_tx_data(app_tx_data),
    .udp_data_length(udp_data_length),
    .m0_tx_ready(m0_tx_ready), .m0_tx_ack(m0_tx_ack),
    .m0_data_request(m0_data_request),
    .m0_data_valid(m0_data_valid),
    .m0_data(m0_data), .m0_data_length(m0_data_length),
    .m1_tx_ready(m1_tx_ready), .m1_tx_ack(m1_tx_ack),
    .m1_data_request(m1_data_request),
    .m1_data_valid(m1_data_valid),
    .m1_data(m1_data), .m1_data_length(m1_data_length),
    .grant(grant), .pkt_done(pkt_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Stimulus knobs, written only by the main sequence
  int drv_mode = 0;
  int ack_mode = 0;
  int v_pct = 75;
  int max_len = 6;
  bit rdy_on = 1'b0;
  bit r0_on = 1'b0, r1_on = 1'b0, v0_on = 1'b0, v1_on = 1'b0;
  logic [15:0] len0 = 16'd0, len1 = 16'd0;

  always @(posedge clk) begin
    #2;
    if (drv_mode == 1) begin
      udp_tx_ready    = ($urandom % 10) != 0;
      m0_data_request = ($urandom % 4) != 0;
      m1_data_request = ($urandom % 4) != 0;
      m0_data_valid   = ($urandom % 100) < v_pct;
      m1_data_valid   = ($urandom % 100) < v_pct;
      m0_data         = 8'($urandom);
      m1_data         = 8'($urandom);
      m0_data_length  = 16'($urandom_range(max_len, 1));
      m1_data_length  = 16'($urandom_range(max_len, 1));
    end else begin
      udp_tx_ready    = rdy_on;
      m0_data_request = r0_on;
      m1_data_request = r1_on;
      m0_data_valid   = v0_on;
      m1_data_valid   = v1_on;
      m0_data         = m0_data + 8'd1;
      m1_data         = m1_data + 8'd7;
      m0_data_length  = len0;
      m1_data_length  = len1;
    end
    #1;
    case (ack_mode)
      1: app_tx_ack = app_tx_data_request;
      2: app_tx_ack = (($urandom % 4) == 0) ||
                      (app_tx_data_request && ($urandom % 2 == 1));
      default: app_tx_ack = 1'b0;
    endcase
  end

  // Reference model: packet owner, bytes left, idle run, gap left
  int  ph, owner, mlen, left, quiet, gap_left, last;
  bit  e_pd, e_to;

  function automatic logic req_of(int n);
    return (n == 1) ? m1_data_request : m0_data_request;
  endfunction
  function automatic logic val_of(int n);
    return (n == 1) ? m1_data_valid : m0_data_valid;
  endfunction
  function automatic logic [7:0] dat_of(int n);
    return (n == 1) ? m1_data : m0_data;
  endfunction

  task automatic end_pkt(bit ok);
    if (ok) e_pd = 1'b1;
    else    e_to = 1'b1;
    last     = owner;
    gap_left = G;
    ph       = P_GAP;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; owner = -1; mlen = 0; left = 0;
      quiet = 0; gap_left = 0; last = 1;
      e_pd = 1'b0; e_to = 1'b0;
    end else begin
      e_pd = 1'b0;
      e_to = 1'b0;
      case (ph)
        P_IDLE:
          if (udp_tx_ready &&
              (m0_data_request || m1_data_request)) begin
            if (m0_data_request && m1_data_request)
              owner = 1 - last;
            else
              owner = m1_data_request ? 1 : 0;
            mlen = (owner == 1) ? int'(m1_data_length)
                                : int'(m0_data_length);
            left = mlen;
            ph   = P_REQ;
          end
        P_REQ:
          if (app_tx_ack) begin
            if (left == 0) end_pkt(1'b1);
            else begin ph = P_DATA; quiet = 0; end
          end else if (!req_of(owner)) begin
            owner = -1;
            ph    = P_IDLE;
          end
        P_DATA:
          if (val_of(owner)) begin
            left--;
            quiet = 0;
            if (left == 0) end_pkt(1'b1);
          end else begin
            quiet++;
            if (quiet == TO) end_pkt(1'b0);
          end
        default: begin
          gap_left--;
          if (gap_left == 0) begin
            owner = -1;
            ph    = P_IDLE;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    logic ev;
    eg = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    ev = (ph == P_DATA) && val_of(owner);
    chk("grant", grant, eg);
    chk("request", app_tx_data_request,
        (ph == P_REQ) && req_of(owner));
    chk("valid", app_tx_data_valid, ev);
    if (ev && app_tx_data_valid)
      chk("data", app_tx_data, dat_of(owner));
    chk("length", udp_data_length, mlen);
    chk("m0_ready", m0_tx_ready, udp_tx_ready &&
        (ph == P_IDLE || (ph == P_REQ && owner == 0)));
    chk("m1_ready", m1_tx_ready, udp_tx_ready &&
        (ph == P_IDLE || (ph == P_REQ && owner == 1)));
    chk("m0_ack", m0_tx_ack,
        app_tx_ack && ph == P_REQ && owner == 0);
    chk("m1_ack", m1_tx_ack,
        app_tx_ack && ph == P_REQ && owner == 1);
    chk("pkt_done", pkt_done, e_pd);
    chk("timeout_err", timeout_err, e_to);
  end

  // Observer of what the stack side actually saw
  logic [7:0] q_bytes[$];
  int pkt_lens[$];
  int grants[$];
  int cyc = 0, pd_cnt = 0, to_cnt = 0, pkt_bytes = 0;
  int pd_cyc = 0, to_cyc = 0, gfall_cyc = 0, byte_cyc = 0;
  logic [1:0] prev_grant = 2'b00;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        grants.push_back(int'(grant));
        pkt_bytes = 0;
      end
      if (grant == 2'b00 && prev_grant != 2'b00)
        gfall_cyc = cyc;
      if (app_tx_data_valid) begin
        q_bytes.push_back(app_tx_data);
        pkt_bytes++;
        byte_cyc = cyc;
      end
      if (pkt_done) begin
        pd_cnt++;
        pd_cyc = cyc;
        pkt_lens.push_back(pkt_bytes);
      end
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      prev_grant = grant;
    end else begin
      prev_grant = 2'b00;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drv_mode = 0; ack_mode = 0; rdy_on = 1'b1;
    r0_on = 1'b0; r1_on = 1'b0; v0_on = 1'b0; v1_on = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  int b_q, b_pl, b_g, b_pd, b_to, k;

  task automatic mark();
    b_q  = q_bytes.size();
    b_pl = pkt_lens.size();
    b_g  = grants.size();
    b_pd = pd_cnt;
    b_to = to_cnt;
  endtask

  task automatic wait_pd(int n, int limit, string name);
    k = 0;
    while (pd_cnt - b_pd < n && k < limit) begin
      step();
      k++;
    end
    chk(name, pd_cnt - b_pd, n);
  endtask

  initial begin
    int bad;
    do_reset();
    mark();
    // Reset values with the stack ready
    chk("rst_grant", grant, 2'b00);
    chk("rst_len", udp_data_length, 16'd0);
    chk("rst_m0_ready", m0_tx_ready, 1'b1);

    // 636-byte packet from m0 alone
    len0 = 16'd636; r0_on = 1'b1; v0_on = 1'b1; ack_mode = 1;
    k = 0;
    while (!app_tx_data_valid && k < 20) begin step(); k++; end
    r0_on = 1'b0;
    wait_pd(1, 800, "t1_pkt_done");
    repeat (25) step();
    chk("t1_pulses", pd_cnt - b_pd, 1);
    chk("t1_bytes", q_bytes.size() - b_q, 636);
    bad = 0;
    for (int i = b_q + 1; i < q_bytes.size(); i++)
      if (q_bytes[i] != q_bytes[i-1] + 8'd1) bad++;
    chk("t1_sequence", bad, 0);
    chk("t1_gap", gfall_cyc - pd_cyc, G);

    // Both requesting, length 4: strict alternation from m0
    do_reset();
    mark();
    len0 = 16'd4; len1 = 16'd4; ack_mode = 1;
    r0_on = 1'b1; r1_on = 1'b1; v0_on = 1'b1; v1_on = 1'b1;
    wait_pd(4, 400, "t2_pkts");
    chk("t2_ngrants", grants.size() - b_g >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (b_g + i < grants.size())
        chk("t2_grant", grants[b_g+i], (i % 2 == 0) ? 1 : 2);
      if (b_pl + i < pkt_lens.size())
        chk("t2_pkt_len", pkt_lens[b_pl+i], 4);
    end

    // m1 length 3 keeps valid high: extra bytes masked
    do_reset();
    mark();
    len1 = 16'd3; r1_on = 1'b1; v1_on = 1'b1; ack_mode = 1;
    wait_pd(1, 50, "t3_pkt_done");
    r1_on = 1'b0;
    repeat (5) step();
    chk("t3_bytes", q_bytes.size() - b_q, 3);
    if (q_bytes.size() - b_q == 3) begin
      chk("t3_b1", q_bytes[b_q+1], q_bytes[b_q] + 8'd7);
      chk("t3_b2", q_bytes[b_q+2], q_bytes[b_q] + 8'd14);
    end

    // m0 stalls after 6 of 10 bytes; m1 waits behind it
    do_reset();
    mark();
    len0 = 16'd10; len1 = 16'd2; r0_on = 1'b1; v0_on = 1'b1;
    ack_mode = 1;
    k = 0;
    while (q_bytes.size() - b_q < 6 && k < 50) begin
      step();
      k++;
    end
    v0_on = 1'b0; r0_on = 1'b0; r1_on = 1'b1;
    k = 0;
    while (to_cnt == b_to && k < 300) begin step(); k++; end
    chk("t4_timeout", to_cnt - b_to, 1);
    chk("t4_bytes", q_bytes.size() - b_q, 6);
    chk("t4_delay", to_cyc - byte_cyc, TO + 1);
    chk("t4_no_done", pd_cnt - b_pd, 0);
    k = 0;
    while (grants.size() - b_g < 2 && k < 60) begin
      step();
      k++;
    end
    chk("t4_next_owner",
        (grants.size() - b_g >= 2) ? grants[b_g+1] : 0, 2);
    r1_on = 1'b0;

    // m0 withdraws before ack: pointer must not move
    do_reset();
    mark();
    r0_on = 1'b1;
    k = 0;
    while (!app_tx_data_request && k < 10) begin step(); k++; end
    r0_on = 1'b0;
    step();
    chk("t5_release", grant, 2'b00);
    len0 = 16'd2; len1 = 16'd2; ack_mode = 1;
    r0_on = 1'b1; r1_on = 1'b1; v0_on = 1'b1; v1_on = 1'b1;
    wait_pd(1, 50, "t5_pkt_done");
    chk("t5_no_timeout", to_cnt - b_to, 0);
    chk("t5_owner",
        (grants.size() - b_g >= 2) ? grants[b_g+1] : 0, 1);

    // Reset in the middle of a long packet, then a clean one
    do_reset();
    mark();
    len0 = 16'd636; r0_on = 1'b1; v0_on = 1'b1; ack_mode = 1;
    k = 0;
    while (q_bytes.size() - b_q < 300 && k < 400) begin
      step();
      k++;
    end
    rst_n = 1'b0;
    #1;
    chk("t6_request", app_tx_data_request, 1'b0);
    chk("t6_valid", app_tx_data_valid, 1'b0);
    chk("t6_data", app_tx_data, 8'h00);
    chk("t6_len", udp_data_length, 16'd0);
    chk("t6_grant", grant, 2'b00);
    chk("t6_pulses", {pkt_done, timeout_err}, 2'b00);
    chk("t6_acks", {m0_tx_ack, m1_tx_ack}, 2'b00);
    repeat (2) step();
    rst_n = 1'b1;
    mark();
    k = 0;
    while (!app_tx_data_valid && k < 20) begin step(); k++; end
    r0_on = 1'b0;
    wait_pd(1, 800, "t6_pkt_done");
    chk("t6_pkt_len",
        (pkt_lens.size() > b_pl) ? pkt_lens[b_pl] : 0, 636);

    // Random traffic, busy then sparse enough to hit the watchdog
    do_reset();
    drv_mode = 1; ack_mode = 2; v_pct = 75; max_len = 6;
    repeat (4000) step();
    v_pct = 3; max_len = 3;
    repeat (4000) step();
    idle_inputs();
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
